// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and latency helpers for the register-scoreboard hazard unit.
// Latencies count cycles from issue until a result can be consumed by ID.
package hazard_scoreboard_pkg;

  typedef logic [4:0] reg_addr_t;
  typedef logic [2:0] lat_t;

  function automatic int calc_max_lat(int load_lat, int wb_dist);
    return wb_dist - 1 + load_lat + 1;
  endfunction

  // Without forwarding every writer waits for writeback; loads add their extra delay.
  function automatic int issue_lat(bit is_load, bit fwd_en, int load_lat, int wb_dist);
    if (fwd_en) return is_load ? load_lat + 1 : 0;
    return is_load ? wb_dist - 1 + load_lat : wb_dist - 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage view of the hazard unit: decoded instruction fields in, stall controls out.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int STAT_W   = 32
);
  localparam int AW = $clog2(NUM_REGS);

  logic              id_valid;
  logic [AW-1:0]     if_id_rs1;
  logic [AW-1:0]     if_id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [AW-1:0]     id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              pipe_hold;
  logic              stall;
  logic              pc_write_;
  logic              if_id_write;
  logic              id_ex_bubble;
  logic [NUM_REGS-1:0] busy_vec;
  logic [STAT_W-1:0] stall_cycles;

  modport master (
    output id_valid, if_id_rs1, if_id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_mem_read, flush, pipe_hold,
    input  stall, pc_write_, if_id_write, id_ex_bubble, busy_vec, stall_cycles
  );

  modport slave (
    input  id_valid, if_id_rs1, if_id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_mem_read, flush, pipe_hold,
    output stall, pc_write_, if_id_write, id_ex_bubble, busy_vec, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard_reg_counter.sv
// One register's pending-result countdown: load on issue, otherwise count down to zero.
module hazard_scoreboard_reg_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // A new issue to this register overrides the decrement of the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register countdowns stall ID until its sources are consumable.
// Flush kills the ID instruction outright; pipe_hold freezes all state and suppresses bubbles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 0,
  parameter int FWD_EN   = 1,
  parameter int WB_DIST  = 3,
  parameter int STAT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);

  localparam int AW      = $clog2(NUM_REGS);
  localparam int MAX_LAT = calc_max_lat(LOAD_LAT, WB_DIST);
  localparam int LAT_W   = $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] LD_VAL  = LAT_W'(issue_lat(1'b1, FWD_EN != 0, LOAD_LAT, WB_DIST));
  localparam logic [LAT_W-1:0] ALU_VAL = LAT_W'(issue_lat(1'b0, FWD_EN != 0, LOAD_LAT, WB_DIST));

  logic [LAT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic                w_hz;
  logic                w_issue;
  logic [LAT_W-1:0]    w_issue_val;
  logic                w_stall;
  logic [STAT_W-1:0]   r_stall_cycles;

  assign w_cnt[0] = '0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_cnt
      hazard_scoreboard_reg_counter #(.W(LAT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_issue && (bus.id_rd == AW'(r))),
        .i_load_val (w_issue_val),
        .i_dec      (~bus.pipe_hold),
        .o_cnt      (w_cnt[r])
      );
    end
  endgenerate

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < NUM_REGS; i++) w_busy[i] = (w_cnt[i] != '0);
  end

  // x0 has a hard-wired zero counter, so the rs!=0 terms fall out of w_busy.
  assign w_hz = bus.id_valid &&
                ((bus.id_rs1_used && w_busy[bus.if_id_rs1]) ||
                 (bus.id_rs2_used && w_busy[bus.if_id_rs2]));

  assign w_issue = bus.id_valid && !w_hz && !bus.flush && !bus.pipe_hold &&
                   bus.id_reg_write && (bus.id_rd != '0);
  assign w_issue_val = bus.id_mem_read ? LD_VAL : ALU_VAL;

  assign w_stall = w_hz && !bus.flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && !bus.pipe_hold && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + STAT_W'(1);
    end
  end

  assign bus.stall        = w_stall;
  assign bus.pc_write_    = rst || !(w_stall || bus.pipe_hold);
  assign bus.if_id_write  = rst || !(w_stall || bus.pipe_hold);
  assign bus.id_ex_bubble = w_stall && !bus.pipe_hold;
  assign bus.busy_vec     = rst ? '0 : w_busy;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Random ID-stage traffic into three configurations, checked against a ready-time model.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_rst, s_valid, s_u1, s_u2, s_rw, s_ld, s_flush, s_hold;
  logic [4:0] s_rs1, s_rs2, s_rd;

  hazard_scoreboard_if #(.NUM_REGS(32), .STAT_W(32)) bus0 ();
  hazard_scoreboard_if #(.NUM_REGS(32), .STAT_W(3))  bus1 ();
  hazard_scoreboard_if #(.NUM_REGS(32), .STAT_W(32)) bus2 ();

  `define TB_DRIVE(B) \
    assign B.id_valid = s_valid; assign B.if_id_rs1 = s_rs1; assign B.if_id_rs2 = s_rs2; \
    assign B.id_rs1_used = s_u1; assign B.id_rs2_used = s_u2; assign B.id_rd = s_rd; \
    assign B.id_reg_write = s_rw; assign B.id_mem_read = s_ld; \
    assign B.flush = s_flush; assign B.pipe_hold = s_hold;
  `TB_DRIVE(bus0)
  `TB_DRIVE(bus1)
  `TB_DRIVE(bus2)

  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(0), .FWD_EN(1), .WB_DIST(3), .STAT_W(32))
    u_dut0 (.clk(clk), .rst(s_rst), .bus(bus0.slave));
  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(2), .FWD_EN(0), .WB_DIST(3), .STAT_W(3))
    u_dut1 (.clk(clk), .rst(s_rst), .bus(bus1.slave));
  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(2), .FWD_EN(1), .WB_DIST(3), .STAT_W(32))
    u_dut2 (.clk(clk), .rst(s_rst), .bus(bus2.slave));

  typedef struct {
    logic        stall, pcw, ifw, bub;
    logic [31:0] busy;
    logic [63:0] sc;
  } obs_t;

  typedef struct {
    int   d;
    obs_t v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: a register is pending while the count of unfrozen edges is below its ready time.
  int     ready_at [3][32];
  int     act_edges;
  longint sc_m [3];

  function automatic int load_lat(int d);  return (d == 0) ? 0 : 2; endfunction
  function automatic bit fwd_en(int d);    return d != 1;           endfunction
  function automatic longint sc_max(int d); return (d == 1) ? 64'd7 : 64'hFFFF_FFFF; endfunction

  function automatic int lat_of(int d, bit is_load);
    if (fwd_en(d)) return is_load ? load_lat(d) + 1 : 0;
    return is_load ? 2 + load_lat(d) : 2;
  endfunction

  function automatic bit pending(int d, logic [4:0] r);
    return (r != 0) && (ready_at[d][r] > act_edges);
  endfunction

  function automatic bit hz_of(int d);
    return s_valid && ((s_u1 && pending(d, s_rs1)) || (s_u2 && pending(d, s_rs2)));
  endfunction

  function automatic obs_t expect_of(int d);
    obs_t o;
    o.stall = !s_rst && hz_of(d) && !s_flush;
    o.pcw   = s_rst || !(o.stall || s_hold);
    o.ifw   = o.pcw;
    o.bub   = o.stall && !s_hold;
    o.busy  = '0;
    for (int r = 0; r < 32; r++) o.busy[r] = !s_rst && pending(d, 5'(r));
    o.sc    = 64'(sc_m[d]);
    return o;
  endfunction

  task automatic model_edge();
    bit hz, st;
    for (int d = 0; d < 3; d++) begin
      hz = hz_of(d);
      st = hz && !s_flush;
      if (s_rst) begin
        for (int r = 0; r < 32; r++) ready_at[d][r] = 0;
        sc_m[d] = 0;
      end else begin
        if (st && !s_hold && sc_m[d] < sc_max(d)) sc_m[d]++;
        if (s_valid && !hz && !s_flush && !s_hold && s_rw && s_rd != 0)
          ready_at[d][s_rd] = act_edges + 1 + lat_of(d, s_ld);
      end
    end
    if (!s_hold) act_edges++;
  endtask

  function automatic obs_t observe(int d);
    obs_t o;
    case (d)
      0: begin o.stall = bus0.stall; o.pcw = bus0.pc_write_; o.ifw = bus0.if_id_write;
               o.bub = bus0.id_ex_bubble; o.busy = bus0.busy_vec; o.sc = 64'(bus0.stall_cycles); end
      1: begin o.stall = bus1.stall; o.pcw = bus1.pc_write_; o.ifw = bus1.if_id_write;
               o.bub = bus1.id_ex_bubble; o.busy = bus1.busy_vec; o.sc = 64'(bus1.stall_cycles); end
      default: begin o.stall = bus2.stall; o.pcw = bus2.pc_write_; o.ifw = bus2.if_id_write;
               o.bub = bus2.id_ex_bubble; o.busy = bus2.busy_vec; o.sc = 64'(bus2.stall_cycles); end
    endcase
    return o;
  endfunction

  task automatic chk(string nm, int d, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h at %0t", nm, d, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    obs_t g;
    while (q.size() > 0) begin
      e = q.pop_front();
      g = observe(e.d);
      chk("stall",        e.d, 64'(g.stall), 64'(e.v.stall));
      chk("pc_write_",    e.d, 64'(g.pcw),   64'(e.v.pcw));
      chk("if_id_write",  e.d, 64'(g.ifw),   64'(e.v.ifw));
      chk("id_ex_bubble", e.d, 64'(g.bub),   64'(e.v.bub));
      chk("busy_vec",     e.d, 64'(g.busy),  64'(e.v.busy));
      chk("stall_cycles", e.d, g.sc,         e.v.sc);
    end
  end

  initial begin
    int hold_left;
    exp_t e;
    s_rst = 1'b1; s_valid = 1'b0; s_u1 = 1'b0; s_u2 = 1'b0; s_rw = 1'b0; s_ld = 1'b0;
    s_flush = 1'b0; s_hold = 1'b0; s_rs1 = '0; s_rs2 = '0; s_rd = '0;
    act_edges = 0;
    hold_left = 0;
    for (int d = 0; d < 3; d++) begin
      sc_m[d] = 0;
      for (int r = 0; r < 32; r++) ready_at[d][r] = 0;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (hold_left == 0 && $urandom_range(0, 19) == 0) hold_left = $urandom_range(1, 5);
      s_hold    = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      s_rst     = (cyc < 2) || ($urandom_range(0, 79) == 0);
      s_valid   = ($urandom_range(0, 99) < 85);
      s_flush   = ($urandom_range(0, 99) < 10);
      s_rs1     = 5'($urandom_range(0, 7));
      s_rs2     = ($urandom_range(0, 3) == 0) ? s_rs1 : 5'($urandom_range(0, 7));
      s_u1      = ($urandom_range(0, 99) < 80);
      s_u2      = ($urandom_range(0, 99) < 60);
      s_rd      = 5'($urandom_range(0, 7));
      s_rw      = ($urandom_range(0, 99) < 75);
      s_ld      = ($urandom_range(0, 99) < 40);
      for (int d = 0; d < 3; d++) begin
        e.d = d;
        e.v = expect_of(d);
        q.push_back(e);
      end
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
